imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_word_asm.sv | 34 +++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the imem boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef logic [1:0] lane_t;
    localparam lane_t LAST_LANE = 2'd3;

endpackage

// File: rtl/imem_word_asm.sv
// Assembles little-endian 32-bit words from a byte stream.
// Latency: word_done/word_dat are combinational with the 4th byte's strobe.
// Backpressure: none; every byte_vld strobe is consumed.
module imem_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic        word_done
);

    lane_t       lane_q;
    logic [23:0] part_q;

    // Bytes enter at the top and shift down, so after three bytes part_q
    // holds {b2, b1, b0} and the fourth byte completes the word on top.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            lane_q <= '0;
            part_q <= '0;
        end else if (byte_vld) begin
            lane_q <= lane_q + lane_t'(1);
            part_q <= {byte_dat, part_q[23:8]};
        end
    end

    assign word_done = byte_vld && (lane_q == LAST_LANE);
    assign word_dat  = {byte_dat, part_q};

endmodule

// File: rtl/imem_loader.sv
// Boot-time imem programmer: SYNC/COUNT/data[/CHK] frames -> imem writes, holds core while loading.
// Latency: write 1 cycle after 4th byte; load_done/cpu_run 2 cycles after final byte. IMEM_LOADER_CHECKSUM_EN adds CHK byte.
// Backpressure: none; rx strobes must be >= 2 cycles apart, timeout aborts stalled frames.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     imem_we,
    output logic [$clog2(DEPTH)-1:0] imem_waddr,
    output logic [31:0]              imem_wdata,
    output logic                     cpu_run,
    output logic                     load_done,
    output logic                     load_err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    loader_state_t state_q, state_d;
    logic [AW-1:0] widx_q, last_q;
    logic [TW-1:0] tmr_q;
    logic          is_sync, bad_count, busy, timed_out, byte_vld, word_done;
    logic [31:0]   word_dat;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    chk_q;
`endif

    assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);
    assign bad_count = (rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH_B);
    assign busy      = state_q inside {ST_COUNT, ST_DATA, ST_CHECK};
    assign timed_out = busy && !rx_valid && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
    assign byte_vld  = rx_valid && (state_q == ST_DATA);

    imem_word_asm u_asm (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (state_q != ST_DATA),
        .byte_vld  (byte_vld),
        .byte_dat  (rx_data),
        .word_dat  (word_dat),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR: if (is_sync) state_d = ST_COUNT;
            ST_COUNT:        if (rx_valid) state_d = bad_count ? ST_ERR : ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_DATA:         if (word_done && (widx_q == last_q)) state_d = ST_CHECK;
            ST_CHECK:        if (rx_valid) state_d = (rx_data == chk_q) ? ST_DONE : ST_ERR;
`else
            ST_DATA:         if (word_done && (widx_q == last_q)) state_d = ST_DONE;
`endif
            ST_DONE:         state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
        if (timed_out) state_d = ST_ERR;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_run    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            widx_q     <= '0;
            last_q     <= '0;
            tmr_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            imem_we   <= word_done;
            load_done <= (state_q == ST_DONE);
            tmr_q     <= (rx_valid || !busy) ? '0 : tmr_q + TW'(1);

            if (word_done) begin
                imem_waddr <= widx_q;
                imem_wdata <= word_dat;
                widx_q     <= widx_q + AW'(1);
            end

            // Store N-1 so the last-word compare fits the address width.
            if ((state_q == ST_COUNT) && rx_valid) begin
                last_q <= AW'(rx_data - 8'd1);
                widx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk_q  <= '0;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (byte_vld) chk_q <= chk_q ^ rx_data;
`endif

            if ((state_q inside {ST_IDLE, ST_ERR}) && is_sync) begin
                cpu_run  <= 1'b0;
                load_err <= 1'b0;
            end
            if (state_q == ST_DONE) cpu_run <= 1'b1;
            if ((state_d == ST_ERR) && (state_q != ST_ERR)) load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    localparam int         DEPTH = 16;
    localparam int         TMO   = 50;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_run, load_done, load_err;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         checks = 0;
    int         errors = 0;
    int         done_seen = 0;
    int         done_exp = 0;
    logic [7:0] run_chk;

    imem_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every write must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n && imem_we) begin
            check1("we_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check32("waddr", 32'(imem_waddr), 32'(mon_e.a));
                check32("wdata", imem_wdata, mon_e.d);
            end
        end
        if (reset_n && load_done) done_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] addr, input logic [31:0] w);
        logic [7:0] b;
        exp_q.push_back({addr, w});
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            run_chk = run_chk ^ b;
            send_byte(b);
        end
    endtask

    task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic good);
        logic ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ok = good;
`else
        ok = 1'b1;
        if (!good) $display("note: checksum not compiled in, frame loads normally");
`endif
        send_byte(SYNC);
        check1("run_fall", cpu_run, 1'b0);
        check1("err_clear", load_err, 1'b0);
        send_byte(8'(n));
        run_chk = 8'h00;
        send_word(4'd0, w0);
        if (n > 1) send_word(4'd1, w1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(good ? run_chk : ~run_chk);
`endif
        if (ok) begin
            check1("done_early", load_done, 1'b0);
            check1("run_early", cpu_run, 1'b0);
            @(negedge clk);
            check1("done_pulse", load_done, 1'b1);
            check1("run_rise", cpu_run, 1'b1);
            check1("err_low", load_err, 1'b0);
            done_exp++;
            @(negedge clk);
            check1("done_one_cycle", load_done, 1'b0);
        end else begin
            check1("chk_err_set", load_err, 1'b1);
            check1("chk_run_held", cpu_run, 1'b0);
        end
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_we", imem_we, 1'b0);
        check32("rst_waddr", 32'(imem_waddr), 32'd0);
        check32("rst_wdata", imem_wdata, 32'd0);
        check1("rst_run", cpu_run, 1'b1);
        check1("rst_done", load_done, 1'b0);
        check1("rst_err", load_err, 1'b0);
        reset_n = 1'b1;

        repeat (10) @(negedge clk);
        check1("idle_run", cpu_run, 1'b1);
        check1("idle_err", load_err, 1'b0);

        // Garbage before SYNC is ignored.
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'hFF);
        send_byte(8'h12);
        repeat (3) @(negedge clk);
        check1("garbage_run", cpu_run, 1'b1);
        check1("garbage_err", load_err, 1'b0);

        send_frame(2, 32'h12345678, 32'hDEADBEEF, 1'b1);
        send_frame(1, 32'hE2800001, 32'h0, 1'b0);
        send_frame(1, 32'h00000013, 32'h0, 1'b1);

        // Bad counts: zero and DEPTH+1.
        send_byte(SYNC);
        send_byte(8'd0);
        check1("n0_err", load_err, 1'b1);
        check1("n0_run", cpu_run, 1'b0);
        send_byte(SYNC);
        check1("n0_sync_clears", load_err, 1'b0);
        send_byte(8'(DEPTH + 1));
        check1("nbig_err", load_err, 1'b1);
        send_byte(8'h33);
        repeat (2) @(negedge clk);
        check1("err_ignores", load_err, 1'b1);
        check1("err_run", cpu_run, 1'b0);
        send_frame(1, 32'h00100073, 32'h0, 1'b1);

        // Timeout two bytes into a word.
        send_byte(SYNC);
        send_byte(8'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TMO - 1) @(negedge clk);
        check1("tmo_not_yet", load_err, 1'b0);
        @(negedge clk);
        check1("tmo_err", load_err, 1'b1);
        check1("tmo_run", cpu_run, 1'b0);

        // SYNC-valued bytes inside data are plain data.
        send_frame(2, 32'hA5A5A5A5, 32'h000000A5, 1'b1);

        // Reset mid-load: first word already written, second partial.
        send_byte(SYNC);
        send_byte(8'd2);
        run_chk = 8'h00;
        send_word(4'd0, 32'hCAFEF00D);
        send_byte(8'h11);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check1("mid_rst_run", cpu_run, 1'b1);
        check1("mid_rst_err", load_err, 1'b0);
        check1("mid_rst_we", imem_we, 1'b0);
        check32("mid_rst_waddr", 32'(imem_waddr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send_frame(2, 32'h0BADC0DE, 32'hFEEDFACE, 1'b1);

        repeat (5) @(negedge clk);
        check32("sb_empty", 32'(exp_q.size()), 32'd0);
        check32("done_count", 32'(done_seen), 32'(done_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
